// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit frame serializer.
//   tx_state_t      : frame FSM state encoding
//   TX_IDLE_LEVEL   : line level while idle and during stop bits
//   TX_START_LEVEL  : line level of the start bit
//   PAR_EVEN/PAR_ODD: encodings of the par_type input
// ---------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL  = 1'b1;
    localparam logic TX_START_LEVEL = 1'b0;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity.sv
// ---------------------------------------------------------------------------
// uart_tx_parity
// Combinational parity generator for one UART data word.
//   data       in  [DATA_WIDTH-1:0]  word being framed
//   par_type   in  1                 PAR_EVEN or PAR_ODD
//   parity_bit out 1                 bit to place after the data bits
// Even parity makes the total count of ones (data + parity) even, so the
// parity bit is simply the XOR of the data; odd parity inverts it.
// ---------------------------------------------------------------------------
module uart_tx_parity
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_type,
    output logic                  parity_bit
);

    assign parity_bit = (par_type == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx_frame_ser.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_ser
// UART transmit frame serializer: start bit, DATA_WIDTH data bits (LSB or
// MSB first), optional parity bit, STOP_BITS stop bits. Bit timing is set by
// an external one-cycle baud_tick enable.
//
// Parameters:
//   DATA_WIDTH (5..9), STOP_BITS (1 or 2), MSB_FIRST (0 = LSB first)
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active low
//   baud_tick   in   marks the end of the current bit period
//   data_valid  in   word offered on data_in (taken only while !busy)
//   data_in     in   parallel word
//   par_en      in   send a parity bit for this frame (sampled at accept)
//   par_type    in   0 = even, 1 = odd (sampled at accept)
//   tx_out      out  registered serial line, idles high
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse in the first idle cycle after a frame
//
// Build option: define UART_TX_PARITY_EN to build the parity stage. Without
// it par_en/par_type are ignored and DATA always goes straight to STOP.
// ---------------------------------------------------------------------------
module uart_tx_frame_ser
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  par_en,
    input  logic                  par_type,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int              CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_d;
    logic                  done_d;
    logic                  send_parity;
    logic                  parity_level;

    wire accept = (state_q == IDLE) && data_valid;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_bit_q;
    logic par_bit_calc;

    // Parity is computed from the word as presented, so the shifting data
    // register does not need to keep an unmodified copy.
    uart_tx_parity #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data       (data_in),
        .par_type   (par_type),
        .parity_bit (par_bit_calc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (accept) begin
            par_en_q  <= par_en;
            par_bit_q <= par_bit_calc;
        end
    end

    assign send_parity  = par_en_q;
    assign parity_level = par_bit_q;
`else
    logic unused_par_inputs;

    assign unused_par_inputs = par_en ^ par_type;
    assign send_parity       = 1'b0;
    assign parity_level      = TX_IDLE_LEVEL;
`endif

    // Next-state logic. tx_out is registered, so its next value is derived
    // from the next state and next shift register contents; that gives the
    // start bit in the cycle right after the accepting edge.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    state_d = START;
                    shift_d = data_in;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = send_parity ? PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = TX_START_LEVEL;
            DATA:    tx_d = (MSB_FIRST != 0) ? shift_d[DATA_WIDTH-1] : shift_d[0];
            PARITY:  tx_d = parity_level;
            default: tx_d = TX_IDLE_LEVEL;
        endcase
    end

    // State, datapath and output registers; reset abandons any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_out     <= TX_IDLE_LEVEL;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_out     <= tx_d;
            frame_done <= done_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_frame_ser.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame_ser
// Two serializer instances: dut_a with default parameters (8 data bits,
// 1 stop bit, LSB first) and dut_b with 7 data bits, 2 stop bits, MSB first.
// Expected line bits and frame lengths are queued when a word is sent and
// consumed by per-instance monitors on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame_ser;

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_BUILT = 1'b1;
`else
    localparam bit PARITY_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       dv_a = 1'b0;
    logic       dv_b = 1'b0;
    logic [7:0] din_a = '0;
    logic [6:0] din_b = '0;
    logic       par_en = 1'b0;
    logic       par_type = 1'b0;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    int tests = 0;
    int fails = 0;
    int tick_period = 1;
    int tick_phase = 0;
    int cnt_a = 0;
    int cnt_b = 0;

    bit exp_a[$];
    bit exp_b[$];
    int len_a[$];
    int len_b[$];

    always #5 clk = ~clk;

    uart_tx_frame_ser dut_a (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .data_valid (dv_a),
        .data_in    (din_a),
        .par_en     (par_en),
        .par_type   (par_type),
        .tx_out     (tx_a),
        .busy       (busy_a),
        .frame_done (done_a)
    );

    uart_tx_frame_ser #(
        .DATA_WIDTH (7),
        .STOP_BITS  (2),
        .MSB_FIRST  (1)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .data_valid (dv_b),
        .data_in    (din_b),
        .par_en     (1'b0),
        .par_type   (1'b0),
        .tx_out     (tx_b),
        .busy       (busy_b),
        .frame_done (done_b)
    );

    // Baud tick: high every cycle for period 1, otherwise once per period.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tick_period <= 1) begin
                baud_tick = 1'b1;
            end else begin
                tick_phase = (tick_phase + 1) % tick_period;
                baud_tick  = (tick_phase == 0);
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic apply_stimulus_a(input logic [7:0] d, input logic pe, input logic pt, input int per);
        int nbits;
        nbits = 10;
        exp_a.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_a.push_back(d[i]);
        if (pe && PARITY_BUILT) begin
            exp_a.push_back((^d) ^ pt);
            nbits++;
        end
        exp_a.push_back(1'b1);
        len_a.push_back(nbits * per);
        din_a    = d;
        par_en   = pe;
        par_type = pt;
        dv_a     = 1'b1;
        @(posedge clk);
        #1;
        dv_a = 1'b0;
    endtask

    task automatic apply_stimulus_b(input logic [6:0] d, input int per);
        exp_b.push_back(1'b0);
        for (int i = 6; i >= 0; i--) exp_b.push_back(d[i]);
        exp_b.push_back(1'b1);
        exp_b.push_back(1'b1);
        len_b.push_back(10 * per);
        din_b = d;
        dv_b  = 1'b1;
        @(posedge clk);
        #1;
        dv_b = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || busy_a || busy_b) && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_output("drain_bits_a", exp_a.size(), 0);
        check_output("drain_bits_b", exp_b.size(), 0);
        check_output("drain_frames_a", len_a.size(), 0);
        check_output("drain_frames_b", len_b.size(), 0);
    endtask

    // Monitor for dut_a: per-cycle line level, bit boundaries on baud_tick,
    // frame length counted in busy cycles and checked on frame_done.
    always @(negedge clk) begin
        if (!rst) begin
            exp_a.delete();
            len_a.delete();
            cnt_a = 0;
            check_output("a_reset_tx", tx_a, 1);
            check_output("a_reset_busy", busy_a, 0);
        end else begin
            if (busy_a) begin
                cnt_a++;
                if (exp_a.size() == 0) begin
                    check_output("a_busy_without_frame", busy_a, 0);
                end else begin
                    check_output("a_tx_bit", tx_a, exp_a[0]);
                    if (baud_tick) void'(exp_a.pop_front());
                end
            end else begin
                check_output("a_idle_level", tx_a, 1);
            end
            if (done_a) begin
                if (len_a.size() == 0) check_output("a_done_without_frame", done_a, 0);
                else check_output("a_frame_len", cnt_a, len_a.pop_front());
                cnt_a = 0;
            end
        end
    end

    // Monitor for dut_b, same scheme.
    always @(negedge clk) begin
        if (!rst) begin
            exp_b.delete();
            len_b.delete();
            cnt_b = 0;
            check_output("b_reset_tx", tx_b, 1);
            check_output("b_reset_busy", busy_b, 0);
        end else begin
            if (busy_b) begin
                cnt_b++;
                if (exp_b.size() == 0) begin
                    check_output("b_busy_without_frame", busy_b, 0);
                end else begin
                    check_output("b_tx_bit", tx_b, exp_b[0]);
                    if (baud_tick) void'(exp_b.pop_front());
                end
            end else begin
                check_output("b_idle_level", tx_b, 1);
            end
            if (done_b) begin
                if (len_b.size() == 0) check_output("b_done_without_frame", done_b, 0);
                else check_output("b_frame_len", cnt_b, len_b.pop_front());
                cnt_b = 0;
            end
        end
    end

    initial begin
        int n;

        // Power-on reset.
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("reset_tx", tx_a, 1);
        check_output("reset_busy", busy_a, 0);
        check_output("reset_done", done_a, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame, LSB first, one stop bit.
        apply_stimulus_a(8'hA5, 1'b0, 1'b0, 1);
        wait_idle(40);

        // MSB first, 7 data bits, two stop bits.
        apply_stimulus_b(7'h41, 1);
        wait_idle(40);

        // Parity requested: even then odd (ignored when not built).
        apply_stimulus_a(8'h07, 1'b1, 1'b0, 1);
        wait_idle(40);
        apply_stimulus_a(8'h07, 1'b1, 1'b1, 1);
        wait_idle(40);
        apply_stimulus_a(8'h00, 1'b0, 1'b1, 1);
        wait_idle(40);

        // Slow baud: accept on a tick edge so every bit spans 4 cycles.
        tick_period = 4;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!baud_tick && n < 16);
        check_output("tick_align", baud_tick, 1);
        apply_stimulus_a(8'h3C, 1'b0, 1'b0, 4);
        repeat (9) @(posedge clk);
        #1;
        din_a = 8'hFF;
        dv_a  = 1'b1;
        @(posedge clk);
        #1;
        dv_a = 1'b0;
        check_output("ignore_mid_frame_busy", busy_a, 1);
        wait_idle(200);

        // Both instances at slow baud together.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!baud_tick && n < 16);
        din_b = 7'h2A;
        exp_b.push_back(1'b0);
        for (int i = 6; i >= 0; i--) exp_b.push_back(din_b[i]);
        exp_b.push_back(1'b1);
        exp_b.push_back(1'b1);
        len_b.push_back(40);
        dv_b = 1'b1;
        apply_stimulus_a(8'hC3, 1'b0, 1'b0, 4);
        dv_b = 1'b0;
        wait_idle(200);
        tick_period = 1;
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back: valid held high, second word taken in frame_done cycle.
        exp_a.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_a.push_back(i == 0);
        exp_a.push_back(1'b1);
        len_a.push_back(10);
        din_a  = 8'h01;
        par_en = 1'b0;
        dv_a   = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) exp_a.push_back(i != 0);
        len_a.push_back(10);
        din_a = 8'hFF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_a && n < 30);
        check_output("b2b_done_seen", done_a, 1);
        check_output("b2b_busy_in_done_cycle", busy_a, 0);
        @(posedge clk);
        #1;
        dv_a = 1'b0;
        @(negedge clk);
        check_output("b2b_second_busy", busy_a, 1);
        check_output("b2b_second_start", tx_a, 0);
        wait_idle(40);

        // Asynchronous reset in the middle of the data bits.
        apply_stimulus_a(8'h55, 1'b0, 1'b0, 1);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_output("midreset_tx", tx_a, 1);
        check_output("midreset_busy", busy_a, 0);
        check_output("midreset_done", done_a, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check_output("post_reset_busy", busy_a, 0);
        check_output("post_reset_tx", tx_a, 1);
        wait_idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
